accumulation_scheduler: RTL
===========================

// Module: accumulation_scheduler
// PURPOSE
//  Sequences the accumulation counter through a programmed list of loop configurations (slots).
//  Each slot holds start delay, trip count and II. The block drives the counter's state and
//  config inputs, watches its end flag, and inserts a drain gap between slots.
//  It sits between the host/config interface and the execute-stage accumulation logic.
// PARAMETERS
//  N_SLOTS    4   number of config slots (power of 2)
//  DRAIN_CYC  2   idle cycles with state != EXEC between slots (>=1)
//  TMO_W      16  watchdog counter width; RUN timeout = 2**TMO_W-1 cycles
// PORTS
//  clk_i         in   1                 clock
//  rst_n_i       in   1                 reset, asynchronous, active-low
//  cfg_we_i      in   1                 slot write strobe
//  cfg_idx_i     in   $clog2(N_SLOTS)   slot index to write
//  cfg_start_i   in   N_BITS_START_REG  start delay for slot
//  cfg_tc_i      in   N_BITS_TC_REG     trip count for slot
//  cfg_ii_i      in   NBIT_II           initiation interval for slot
//  n_slots_i     in   $clog2(N_SLOTS)+1 slots to run, sampled on go
//  go_i          in   1                 start sequence (honoured only in IDLE)
//  abort_i       in   1                 abandon sequence
//  acc_end_i     in   1                 end flag from accumulation counter (level)
//  acc_state_o   out  state_t           EXEC while running a slot, else IDLE
//  reg_start_o   out  N_BITS_START_REG  active slot start delay
//  reg_tc_o      out  N_BITS_TC_REG     active slot trip count
//  reg_ii_o      out  NBIT_II           active slot II
//  busy_o        out  1                 FSM not in S_IDLE
//  done_o        out  1                 1-cycle pulse: sequence finished (normal, abort or timeout)
//  slot_o        out  $clog2(N_SLOTS)   index of active slot
//  err_o         out  1                 sticky: write while busy, tc==0 slot skipped, or timeout; cleared on go
// BEHAVIOUR
//  Reset: FSM S_IDLE, all outputs 0, acc_state_o=IDLE, slot regs 0, armed=0, watchdog 0.
//  Config: cfg_we_i in S_IDLE writes slot next edge; cfg_we_i while busy dropped, err_o<=1.
//  FSM S_IDLE -> S_LOAD -> S_RUN -> S_DRAIN -> (S_LOAD | S_IDLE):
//   S_IDLE: go_i -> latch n_slots_i, slot=0, err_o<=0; n_slots_i==0 -> done_o pulse next cycle,
//     stay IDLE; n_slots_i>N_SLOTS clamped to N_SLOTS.
//   S_LOAD (1 cycle): reg_*_o <= slot contents, acc_state_o IDLE. tc==0 -> slot skipped
//     (err_o<=1, go to S_DRAIN path decision without EXEC).
//   S_RUN: acc_state_o=EXEC; armed<=1 when acc_end_i==1; slot complete on first cycle with
//     armed==1 && acc_end_i==0 (counter wrapped tc->0, tc+1 accumulations done) -> S_DRAIN.
//   S_DRAIN: acc_state_o=IDLE for DRAIN_CYC cycles, armed<=0; then slot+1 < n_slots -> S_LOAD
//     (slot++), else S_IDLE with done_o pulse on the transition cycle.
//  reg_*_o hold last slot values in S_DRAIN/S_IDLE (counter keeps count=0 after wrap).
//  Watchdog: counts cycles in S_RUN, cleared on S_RUN entry; saturating at all-ones -> err_o<=1,
//   go to S_IDLE, done_o pulse.
//  abort_i: priority over everything except reset; any busy state -> S_IDLE next cycle,
//   acc_state_o IDLE, done_o pulse; ignored in S_IDLE. abort_i with go_i in IDLE: go wins.
//  go_i while busy ignored (no error). Async reset mid-run returns all state to reset values.
//  Latency: go_i edge -> acc_state_o=EXEC after 2 cycles (IDLE->LOAD->RUN).
// TESTING
//  1 slot {start=2,tc=3,II=0}, go -> EXEC 2 cycles after go, RUN exits after end high->low,
//    done_o pulses once after 2 drain cycles, err_o=0.
//  3 slots tc={1,4,2}, II={1,0,2} -> slot_o 0,1,2, each slot sees tc+1 count_en pulses,
//    >=2 non-EXEC cycles between slots, single done_o.
//  Slot 1 of 3 has tc=0 -> skipped, never EXEC for it, err_o=1, slots 0 and 2 run, done_o once.
//  abort_i mid-slot 1 -> next cycle busy_o=0, acc_state_o=IDLE, done_o=1; new go restarts at slot 0.
//  cfg_we_i during RUN -> slot unchanged, err_o=1; go with n_slots_i=0 -> done_o next cycle, no EXEC.
//  TMO_W=4, acc_end_i tied 0 -> after 15 RUN cycles err_o=1, done_o pulse, S_IDLE.

Source files
------------

// File: rtl/accumulation_scheduler.sv
// Sequences the accumulation counter through a programmed list of loop slots,
// with a drain gap between slots, abort handling and a RUN watchdog.
package accumulation_scheduler_pkg;
    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;
endpackage

module accumulation_scheduler
    import accumulation_scheduler_pkg::*;
#(
    parameter int unsigned N_SLOTS          = 4,
    parameter int unsigned DRAIN_CYC        = 2,
    parameter int unsigned TMO_W            = 16,
    parameter int unsigned N_BITS_START_REG = 8,
    parameter int unsigned N_BITS_TC_REG    = 8,
    parameter int unsigned NBIT_II          = 4,
    localparam int unsigned IDX_W           = $clog2(N_SLOTS),
    localparam int unsigned CNT_W           = IDX_W + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        cfg_we_i,
    input  logic [IDX_W-1:0]            cfg_idx_i,
    input  logic [N_BITS_START_REG-1:0] cfg_start_i,
    input  logic [N_BITS_TC_REG-1:0]    cfg_tc_i,
    input  logic [NBIT_II-1:0]          cfg_ii_i,
    input  logic [CNT_W-1:0]            n_slots_i,
    input  logic                        go_i,
    input  logic                        abort_i,
    input  logic                        acc_end_i,
    output state_t                      acc_state_o,
    output logic [N_BITS_START_REG-1:0] reg_start_o,
    output logic [N_BITS_TC_REG-1:0]    reg_tc_o,
    output logic [NBIT_II-1:0]          reg_ii_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [IDX_W-1:0]            slot_o,
    output logic                        err_o
);

    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYC) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} fsm_t;

    fsm_t                        state_q;
    logic [N_BITS_START_REG-1:0] start_mem_q [N_SLOTS];
    logic [N_BITS_TC_REG-1:0]    tc_mem_q    [N_SLOTS];
    logic [NBIT_II-1:0]          ii_mem_q    [N_SLOTS];
    logic [CNT_W-1:0]            n_slots_q;
    logic [IDX_W-1:0]            slot_q;
    logic                        armed_q;
    logic [TMO_W-1:0]            wdog_q;
    logic [DRAIN_W-1:0]          drain_q;
    state_t                      acc_state_q;
    logic [N_BITS_START_REG-1:0] reg_start_q;
    logic [N_BITS_TC_REG-1:0]    reg_tc_q;
    logic [NBIT_II-1:0]          reg_ii_q;
    logic                        done_q;
    logic                        err_q;

    logic [CNT_W-1:0]            n_slots_d;
    logic [CNT_W-1:0]            slot_nxt_d;
    logic [TMO_W-1:0]            wdog_d;

    assign n_slots_d  = (n_slots_i > CNT_W'(N_SLOTS)) ? CNT_W'(N_SLOTS) : n_slots_i;
    assign slot_nxt_d = CNT_W'(slot_q) + CNT_W'(1);
    assign wdog_d     = (wdog_q == '1) ? wdog_q : wdog_q + TMO_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                start_mem_q[i] <= '0;
                tc_mem_q[i]    <= '0;
                ii_mem_q[i]    <= '0;
            end
            n_slots_q   <= '0;
            slot_q      <= '0;
            armed_q     <= 1'b0;
            wdog_q      <= '0;
            drain_q     <= '0;
            acc_state_q <= IDLE;
            reg_start_q <= '0;
            reg_tc_q    <= '0;
            reg_ii_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cfg_we_i) begin
                if (state_q == S_IDLE) begin
                    start_mem_q[cfg_idx_i] <= cfg_start_i;
                    tc_mem_q[cfg_idx_i]    <= cfg_tc_i;
                    ii_mem_q[cfg_idx_i]    <= cfg_ii_i;
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (state_q != S_IDLE && abort_i) begin
                state_q     <= S_IDLE;
                acc_state_q <= IDLE;
                armed_q     <= 1'b0;
                done_q      <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (go_i) begin
                            err_q     <= 1'b0;
                            slot_q    <= '0;
                            n_slots_q <= n_slots_d;
                            if (n_slots_i == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        reg_start_q <= start_mem_q[slot_q];
                        reg_tc_q    <= tc_mem_q[slot_q];
                        reg_ii_q    <= ii_mem_q[slot_q];
                        armed_q     <= 1'b0;
                        if (tc_mem_q[slot_q] == '0) begin
                            err_q   <= 1'b1;
                            drain_q <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            wdog_q      <= '0;
                            acc_state_q <= EXEC;
                            state_q     <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        wdog_q <= wdog_d;
                        if (acc_end_i) begin
                            armed_q <= 1'b1;
                        end
                        // end flag seen high then low: the counter has wrapped tc -> 0
                        if (armed_q && !acc_end_i) begin
                            armed_q     <= 1'b0;
                            drain_q     <= '0;
                            acc_state_q <= IDLE;
                            state_q     <= S_DRAIN;
                        end else if (wdog_d == '1) begin
                            armed_q     <= 1'b0;
                            err_q       <= 1'b1;
                            done_q      <= 1'b1;
                            acc_state_q <= IDLE;
                            state_q     <= S_IDLE;
                        end
                    end
                    S_DRAIN: begin
                        armed_q <= 1'b0;
                        if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                            if (slot_nxt_d < n_slots_q) begin
                                slot_q  <= slot_q + IDX_W'(1);
                                state_q <= S_LOAD;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            drain_q <= drain_q + DRAIN_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign acc_state_o = acc_state_q;
    assign reg_start_o = reg_start_q;
    assign reg_tc_o    = reg_tc_q;
    assign reg_ii_o    = reg_ii_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign slot_o      = slot_q;
    assign err_o       = err_q;

endmodule
